// File: rtl/vga_text_writer_pkg.sv
// Shared constants, character codes and FSM encoding for the VGA text writer.
package vga_text_writer_pkg;

  localparam int C_AXI_DATA_WIDTH = 32;
  localparam int C_AXI_ADDR_WIDTH = 13;
  localparam int N_COL            = 80;
  localparam int N_ROW            = 30;
  localparam int BUF_WORDS        = 600;  // 80*30 chars / 4 per word
  localparam int ROW_WORDS        = 20;   // 80 chars / 4 per word

  localparam logic [12:0] BUF_BASE   = 13'd4096;
  localparam logic [31:0] SPACE_WORD = 32'h20202020;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_PR_LO = 8'h20;
  localparam logic [7:0] CH_PR_HI = 8'h7E;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_WRITE   = 2'd2,
    ST_CLR_ROW = 2'd3
  } state_t;

  // Byte address of a character cell; row*80 = row*64 + row*16 kept in 12 bits.
  function automatic logic [12:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    logic [11:0] lin;
    lin = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
    return BUF_BASE + {1'b0, lin};
  endfunction

endpackage

// File: rtl/vga_text_writer_if.sv
// Byte-stream input and character-buffer write port of the text writer.
interface vga_text_writer_if;
  import vga_text_writer_pkg::*;

  logic                          in_valid_i;
  logic [7:0]                    in_data_i;
  logic                          in_ready_o;
  logic [C_AXI_ADDR_WIDTH-1:0]   axil_waddr_o;
  logic [C_AXI_DATA_WIDTH-1:0]   axil_wdata_o;
  logic [C_AXI_DATA_WIDTH/8-1:0] axil_wstrb_o;
  logic                          axil_wready_o;

  // Writer side: consumes bytes, initiates buffer writes.
  modport master (
    input  in_valid_i, in_data_i,
    output in_ready_o, axil_waddr_o, axil_wdata_o, axil_wstrb_o, axil_wready_o
  );

  // Environment side: byte source and buffer write target.
  modport slave (
    output in_valid_i, in_data_i,
    input  in_ready_o, axil_waddr_o, axil_wdata_o, axil_wstrb_o, axil_wready_o
  );
endinterface

// File: rtl/vga_text_writer_cursor.sv
// 80x30 text cursor: column/row counters with wrap, plus a one-cycle row_adv
// pulse in the cycle after the row changed (row already holds the new value).
module vga_text_writer_cursor
  import vga_text_writer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       cr,
  input  logic       lf,
  input  logic       home,
  output logic [6:0] col,
  output logic [4:0] row,
  output logic       row_adv
);

  logic       col_last;
  logic       adv;
  logic [4:0] row_nxt;

  // Wrap detection and next-row value (no scrolling, row 29 wraps to 0).
  always_comb begin
    col_last = (col == 7'(N_COL - 1));
    adv      = lf | (inc & col_last);
    row_nxt  = (row == 5'(N_ROW - 1)) ? 5'd0 : row + 5'd1;
  end

  // Cursor registers; home has priority, the commands are otherwise exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      row_adv <= 1'b0;
    end else begin
      row_adv <= 1'b0;
      if (home) begin
        col <= '0;
        row <= '0;
      end else begin
        if (adv) begin
          row     <= row_nxt;
          row_adv <= 1'b1;
        end
        if (lf || cr || (inc && col_last)) col <= '0;
        else if (inc)                      col <= col + 7'd1;
        else if (dec && (col != 7'd0))     col <= col - 7'd1;
      end
    end
  end

endmodule

// File: rtl/vga_text_writer.sv
// Byte stream to character-buffer writer. The FSM computes next-cycle bus values
// combinationally and registers them, so every bus output lags its decision by one cycle.
module vga_text_writer
  import vga_text_writer_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  vga_text_writer_if.master  bus,
  output logic [6:0]         cur_col_o,
  output logic [4:0]         cur_row_o,
  output logic               busy_o
);

  state_t      state, state_n;
  logic [9:0]  cnt, cnt_n;
  logic        in_ready_n, wready_n, busy_n;
  logic [12:0] waddr_n, row_base;
  logic [31:0] wdata_n;
  logic [3:0]  wstrb_n;
  logic        inc, dec, cr, lf, home, row_adv;
  logic        hs, is_print;
  logic [7:0]  ch;

  vga_text_writer_cursor u_cursor (
    .clk     (clk_i),
    .rst     (rst_i),
    .inc     (inc),
    .dec     (dec),
    .cr      (cr),
    .lf      (lf),
    .home    (home),
    .col     (cur_col_o),
    .row     (cur_row_o),
    .row_adv (row_adv)
  );

  // Next state, burst counter, cursor commands and next bus values.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    in_ready_n = 1'b0;
    wready_n   = 1'b0;
    waddr_n    = '0;
    wdata_n    = '0;
    wstrb_n    = '0;
    inc        = 1'b0;
    dec        = 1'b0;
    cr         = 1'b0;
    lf         = 1'b0;
    home       = 1'b0;
    hs         = bus.in_valid_i & bus.in_ready_o;
    ch         = bus.in_data_i;
    is_print   = (ch >= CH_PR_LO) && (ch <= CH_PR_HI);
    row_base   = cell_addr(cur_row_o, 7'd0);

    case (state)
      ST_CLEAR: begin
        wready_n = 1'b1;
        waddr_n  = BUF_BASE + {1'b0, cnt, 2'b00};
        wdata_n  = SPACE_WORD;
        wstrb_n  = 4'hF;
        if (cnt == 10'(BUF_WORDS - 1)) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 10'd1;
        end
      end

      ST_IDLE: begin
        in_ready_n = 1'b1;
        if (hs) begin
          if (is_print) begin
            in_ready_n = 1'b0;
            wready_n   = 1'b1;
            waddr_n    = cell_addr(cur_row_o, cur_col_o);
            wdata_n    = {4{ch}};
            wstrb_n    = 4'b0001 << waddr_n[1:0];
            inc        = 1'b1;
            state_n    = ST_WRITE;
          end else begin
            case (ch)
              CH_BS: begin
                if (cur_col_o != 7'd0) begin
                  in_ready_n = 1'b0;
                  wready_n   = 1'b1;
                  waddr_n    = cell_addr(cur_row_o, cur_col_o - 7'd1);
                  wdata_n    = SPACE_WORD;
                  wstrb_n    = 4'b0001 << waddr_n[1:0];
                  dec        = 1'b1;
                  state_n    = ST_WRITE;
                end
              end
              CH_CR: cr = 1'b1;
              CH_LF: begin
                in_ready_n = 1'b0;
                lf         = 1'b1;
                cnt_n      = '0;
                state_n    = ST_CLR_ROW;
              end
              CH_FF: begin
                in_ready_n = 1'b0;
                home       = 1'b1;
                cnt_n      = '0;
                state_n    = ST_CLEAR;
              end
              default: ;  // unsupported control codes are dropped
            endcase
          end
        end
      end

      // The write itself was issued on entry; a wrap at col 79 chains straight
      // into the row clear with word 0 in the very next bus cycle.
      ST_WRITE: begin
        if (row_adv) begin
          wready_n = 1'b1;
          waddr_n  = row_base;
          wdata_n  = SPACE_WORD;
          wstrb_n  = 4'hF;
          cnt_n    = 10'd1;
          state_n  = ST_CLR_ROW;
        end else begin
          in_ready_n = 1'b1;
          state_n    = ST_IDLE;
        end
      end

      ST_CLR_ROW: begin
        wready_n = 1'b1;
        waddr_n  = row_base + {1'b0, cnt, 2'b00};
        wdata_n  = SPACE_WORD;
        wstrb_n  = 4'hF;
        if (cnt == 10'(ROW_WORDS - 1)) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 10'd1;
        end
      end

      default: state_n = ST_CLEAR;
    endcase

    busy_n = wready_n | (state_n != ST_IDLE);
  end

  // State and registered bus outputs; reset abandons any burst and restarts CLEAR.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= ST_CLEAR;
      cnt               <= '0;
      bus.in_ready_o    <= 1'b0;
      bus.axil_wready_o <= 1'b0;
      bus.axil_waddr_o  <= '0;
      bus.axil_wdata_o  <= '0;
      bus.axil_wstrb_o  <= '0;
      busy_o            <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      bus.in_ready_o    <= in_ready_n;
      bus.axil_wready_o <= wready_n;
      bus.axil_waddr_o  <= waddr_n;
      bus.axil_wdata_o  <= wdata_n;
      bus.axil_wstrb_o  <= wstrb_n;
      busy_o            <= busy_n;
    end
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer: captures every write cycle and compares
// against hand-computed addresses, data, strobes and cursor positions.
module tb_vga_text_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  vga_text_writer_if bus();
  logic [6:0] col;
  logic [4:0] row;
  logic       busy;

  vga_text_writer dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .cur_col_o (col),
    .cur_row_o (row),
    .busy_o    (busy)
  );

  typedef struct {
    logic [12:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          c;
  } wr_t;

  wr_t wq[$];
  int  n_cmp = 0, n_bad = 0;
  int  cyc = 0, bad_addr = 0, overlap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture write cycles and bus invariants away from the active edge.
  always @(negedge clk) begin
    if (bus.axil_wready_o) begin
      wq.push_back('{a: bus.axil_waddr_o, d: bus.axil_wdata_o, s: bus.axil_wstrb_o, c: cyc});
      if (bus.axil_waddr_o >= 13'd6496) bad_addr++;
      if (bus.in_ready_o) overlap++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    if (i < wq.size()) begin
      chk({tag, "_addr"}, 32'(wq[i].a), a);
      chk({tag, "_data"}, wq[i].d, d);
      chk({tag, "_strb"}, 32'(wq[i].s), 32'(s));
    end else begin
      chk({tag, "_present"}, wq.size(), i + 1);
    end
  endtask

  // n contiguous space words starting at byte address base.
  task automatic check_span(input string tag, input int first, input int n, input int base);
    int bad = 0;
    for (int j = 0; j < n; j++) begin
      if (first + j >= wq.size()) bad++;
      else begin
        if (32'(wq[first+j].a) != base + 4*j || wq[first+j].d !== 32'h20202020 ||
            wq[first+j].s !== 4'hF) bad++;
        if (j > 0 && wq[first+j].c != wq[first+j-1].c + 1) bad++;
      end
    end
    chk(tag, bad, 0);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = b;
    while (!bus.in_ready_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(bus.in_ready_o), 1);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(bus.in_ready_o && !busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.in_ready_o & ~busy), 1);
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_wready", 32'(bus.axil_wready_o), 0);
    chk("rst_ready",  32'(bus.in_ready_o), 0);
    chk("rst_waddr",  32'(bus.axil_waddr_o), 0);
    chk("rst_col",    32'(col), 0);
    chk("rst_row",    32'(row), 0);
    chk("rst_busy",   32'(busy), 0);

    // power-up clear
    wq.delete();
    rst = 1'b0;
    wait_idle("idle_clear");
    chk("clr_cnt", wq.size(), 600);
    check_span("clr_words", 0, 600, 4096);

    // single printable
    wq.delete();
    send(8'h41);
    wait_idle("idle_A");
    chk("A_cnt", wq.size(), 1);
    chk_wr("A", 0, 4096, 32'h41414141, 4'b0001);
    chk("A_col", 32'(col), 1);
    chk("A_row", 32'(row), 0);

    // back-to-back printables: one write every 2 cycles
    wq.delete();
    send(8'h78);
    send(8'h79);
    wait_idle("idle_xy");
    chk("xy_cnt", wq.size(), 2);
    chk_wr("x", 0, 4097, 32'h78787878, 4'b0010);
    chk_wr("y", 1, 4098, 32'h79797979, 4'b0100);
    if (wq.size() == 2) chk("tput", wq[1].c - wq[0].c, 2);

    // CR and a dropped control code
    wq.delete();
    send(8'h0D);
    wait_idle("idle_cr");
    chk("cr_col", 32'(col), 0);
    send(8'h01);
    wait_idle("idle_drop");
    chk("cr_drop_nowr", wq.size(), 0);
    chk("drop_col", 32'(col), 0);
    chk("drop_row", 32'(row), 0);

    // form feed
    wq.delete();
    send(8'h0C);
    wait_idle("idle_ff");
    chk("ff_cnt", wq.size(), 600);
    check_span("ff_words", 0, 600, 4096);

    // 80 printables: wrap at col 79, then clear row 1
    wq.delete();
    repeat (80) send(8'h42);
    wait_idle("idle_B");
    chk("B_cnt", wq.size(), 100);
    chk_wr("B0", 0, 4096, 32'h42424242, 4'b0001);
    chk_wr("B79", 79, 4175, 32'h42424242, 4'b1000);
    check_span("B_row1", 80, 20, 4176);
    if (wq.size() > 80) chk("B_gap", wq[80].c - wq[79].c, 1);
    chk("B_col", 32'(col), 0);
    chk("B_row", 32'(row), 1);

    // LF on row 29 wraps to row 0 and clears it
    send(8'h0C);
    wait_idle("idle_ff2");
    repeat (29) begin
      send(8'h0A);
      wait_idle("idle_lf");
    end
    repeat (5) send(8'h63);
    wait_idle("idle_c");
    chk("pre_lf_row", 32'(row), 29);
    chk("pre_lf_col", 32'(col), 5);
    wq.delete();
    send(8'h0A);
    wait_idle("idle_lfw");
    chk("lfw_cnt", wq.size(), 20);
    check_span("lfw_words", 0, 20, 4096);
    chk("lfw_col", 32'(col), 0);
    chk("lfw_row", 32'(row), 0);

    // backspace at (3,10), then at col 0
    repeat (3) begin
      send(8'h0A);
      wait_idle("idle_lf3");
    end
    repeat (10) send(8'h64);
    wait_idle("idle_d");
    wq.delete();
    send(8'h08);
    wait_idle("idle_bs");
    chk("bs_cnt", wq.size(), 1);
    chk_wr("bs", 0, 4345, 32'h20202020, 4'b0010);
    chk("bs_col", 32'(col), 9);
    chk("bs_row", 32'(row), 3);
    send(8'h0D);
    wait_idle("idle_cr2");
    wq.delete();
    send(8'h08);
    wait_idle("idle_bs0");
    chk("bs0_cnt", wq.size(), 0);
    chk("bs0_col", 32'(col), 0);
    chk("bs0_row", 32'(row), 3);

    // reset in the middle of a clear burst (word 300 = 4096 + 1200)
    send(8'h0C);
    n = 0;
    while (!(bus.axil_wready_o && bus.axil_waddr_o == 13'd5296) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_word300", 32'(bus.axil_waddr_o), 5296);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_wready", 32'(bus.axil_wready_o), 0);
    rst = 1'b0;
    wq.delete();
    wait_idle("idle_rst");
    chk("rst_clr_cnt", wq.size(), 600);
    check_span("rst_clr_words", 0, 600, 4096);
    chk("rst_col2", 32'(col), 0);
    chk("rst_row2", 32'(row), 0);

    chk("addr_range", bad_addr, 0);
    chk("rdy_wr_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
